// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Start/busy/done handshake and operand/result bundle for the bit-serial
//   subtractor.
//   master modport (requester): drives iStart, iData_a, iData_b, iB and
//                               observes oData, oData_B, oBusy, oDone.
//   slave modport  (subtractor): the same signals in the opposite directions.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             iStart;
    logic [WIDTH-1:0] iData_a;
    logic [WIDTH-1:0] iData_b;
    logic             iB;
    logic [WIDTH-1:0] oData;
    logic             oData_B;
    logic             oBusy;
    logic             oDone;

    modport master (
        output iStart, iData_a, iData_b, iB,
        input  oData, oData_B, oBusy, oDone
    );

    modport slave (
        input  iStart, iData_a, iData_b, iB,
        output oData, oData_B, oBusy, oDone
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor: oData = iData_a - iData_b - iB (modulo 2^WIDTH).
//   It processes one bit per clock, LSB first, and spends WIDTH clock edges
//   per operation. oData_B is the unsigned borrow-out.
//   Ports:
//     iClk  - single clock, all state updates on the rising edge
//     iRst  - asynchronous active-high reset
//     bus   - serial_subtractor_if.slave. It carries the start request, the
//             operands, the borrow-in, the registered result and borrow-out,
//             and the busy/done status.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic                  iClk,
    input logic                  iRst,
    serial_subtractor_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           stateQ;
    logic [WIDTH-1:0] aQ;
    logic [WIDTH-1:0] bQ;
    logic             borrowQ;
    logic [WIDTH-1:0] resultQ;
    logic [CW-1:0]    cntQ;
    logic [WIDTH-1:0] dataQ;
    logic             dataBQ;
    logic             busyQ;
    logic             doneQ;

    logic             diffBitD;
    logic             borrowD;

    // One full-subtractor cell. It works on the current LSBs of the shifting
    // operand registers together with the running borrow.
    always_comb begin
        diffBitD = aQ[0] ^ bQ[0] ^ borrowQ;
        borrowD  = (~aQ[0] & bQ[0]) | (~aQ[0] & borrowQ) | (bQ[0] & borrowQ);
    end

    // Control FSM and datapath.
    // Operands shift right so that bit i is always at position 0.
    // Difference bits enter the result register at the MSB, so after WIDTH
    // shifts the result register holds the full difference.
    // The visible outputs update only on the completion edge. Because of this
    // a partial result is never shown on oData or oData_B.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stateQ  <= IDLE;
            aQ      <= '0;
            bQ      <= '0;
            borrowQ <= 1'b0;
            resultQ <= '0;
            cntQ    <= '0;
            dataQ   <= '0;
            dataBQ  <= 1'b0;
            busyQ   <= 1'b0;
            doneQ   <= 1'b0;
        end else begin
            case (stateQ)
                IDLE, DONE: begin
                    doneQ <= 1'b0;
                    if (bus.iStart) begin
                        aQ      <= bus.iData_a;
                        bQ      <= bus.iData_b;
                        borrowQ <= bus.iB;
                        resultQ <= '0;
                        cntQ    <= '0;
                        busyQ   <= 1'b1;
                        stateQ  <= RUN;
                    end else begin
                        stateQ <= IDLE;
                    end
                end
                RUN: begin
                    aQ      <= aQ >> 1;
                    bQ      <= bQ >> 1;
                    borrowQ <= borrowD;
                    resultQ <= {diffBitD, resultQ[WIDTH-1:1]};
                    if (cntQ == CW'(WIDTH - 1)) begin
                        dataQ  <= {diffBitD, resultQ[WIDTH-1:1]};
                        dataBQ <= borrowD;
                        doneQ  <= 1'b1;
                        busyQ  <= 1'b0;
                        stateQ <= DONE;
                    end else begin
                        cntQ <= cntQ + CW'(1);
                    end
                end
                default: begin
                    busyQ  <= 1'b0;
                    doneQ  <= 1'b0;
                    stateQ <= IDLE;
                end
            endcase
        end
    end

    assign bus.oData   = dataQ;
    assign bus.oData_B = dataBQ;
    assign bus.oBusy   = busyQ;
    assign bus.oDone   = doneQ;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor. The reference result is
//   computed with plain (WIDTH+1)-bit arithmetic: {borrow, diff} = a - b - bin.
module tb_serial_subtractor;
    localparam int WIDTH = 8;

    logic iClk;
    logic iRst;

    int assertCount;
    int failCount;

    logic [WIDTH-1:0] prevData;
    logic             prevB;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus)
    );

    // Free-running clock, period 10.
    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // Compare one observed value with its expected value. Count the
    // comparison, and count and report it if it fails.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present an operation and wait for the accept edge.
    // The task is entered and left 1 time unit after a rising edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bin);
        bus.iStart  = 1'b1;
        bus.iData_a = a;
        bus.iData_b = b;
        bus.iB      = bin;
        @(posedge iClk);
        #1;
        bus.iStart  = 1'b0;
        checkOutput("busy_after_accept", 32'(bus.oBusy), 32'd1);
        checkOutput("done_after_accept", 32'(bus.oDone), 32'd0);
    endtask

    // Wait (bounded) for oDone and check the result against the reference.
    // If glitchCycle > 0, iStart is pulsed with junk operands for one cycle
    // after that many RUN edges; the DUT must ignore the pulse.
    task automatic waitDone(input string tag, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic bin,
                            input int glitchCycle);
        logic [WIDTH:0] full;
        int edges;
        bit seen;
        full  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
        edges = 0;
        seen  = 0;
        while (!seen && edges < WIDTH + 4) begin
            @(posedge iClk);
            #1;
            edges++;
            if (edges == glitchCycle) begin
                bus.iStart  = 1'b1;
                bus.iData_a = WIDTH'($urandom);
                bus.iData_b = WIDTH'($urandom);
                bus.iB      = 1'($urandom);
            end else begin
                bus.iStart = 1'b0;
            end
            checkOutput({tag, "_busy_done_exclusive"}, 32'(bus.oBusy & bus.oDone), 32'd0);
            if (bus.oDone) begin
                seen = 1;
            end else begin
                checkOutput({tag, "_data_held"}, 32'(bus.oData), 32'(prevData));
                checkOutput({tag, "_borrow_held"}, 32'(bus.oData_B), 32'(prevB));
                checkOutput({tag, "_busy_running"}, 32'(bus.oBusy), 32'd1);
            end
        end
        bus.iStart = 1'b0;
        checkOutput({tag, "_latency"}, 32'(edges), 32'(WIDTH));
        checkOutput({tag, "_data"}, 32'(bus.oData), 32'(full[WIDTH-1:0]));
        checkOutput({tag, "_borrow"}, 32'(bus.oData_B), 32'(full[WIDTH]));
        checkOutput({tag, "_busy_at_done"}, 32'(bus.oBusy), 32'd0);
        prevData = full[WIDTH-1:0];
        prevB    = full[WIDTH];
    endtask

    // Run one complete operation. Afterwards check that oDone is a
    // single-cycle pulse and that the FSM settles back to idle.
    task automatic runOp(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic bin);
        applyStimulus(a, b, bin);
        waitDone(tag, a, b, bin, 0);
        @(posedge iClk);
        #1;
        checkOutput({tag, "_done_pulse_end"}, 32'(bus.oDone), 32'd0);
        checkOutput({tag, "_idle_busy"}, 32'(bus.oBusy), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rbin;
        bit               sawDone;

        assertCount = 0;
        failCount   = 0;
        prevData    = '0;
        prevB       = 1'b0;
        iRst        = 1'b1;
        bus.iStart  = 1'b0;
        bus.iData_a = '0;
        bus.iData_b = '0;
        bus.iB      = 1'b0;

        // Reset state.
        repeat (2) @(posedge iClk);
        #1;
        checkOutput("reset_data", 32'(bus.oData), 32'd0);
        checkOutput("reset_borrow", 32'(bus.oData_B), 32'd0);
        checkOutput("reset_busy", 32'(bus.oBusy), 32'd0);
        checkOutput("reset_done", 32'(bus.oDone), 32'd0);
        iRst = 1'b0;
        @(posedge iClk);
        #1;

        // Directed cases: zeros, wrap-around, mixed patterns, and a borrow-in
        // that ripples through the full width.
        runOp("zero", 8'h00, 8'h00, 1'b0);
        runOp("wrap", 8'h00, 8'h01, 1'b0);
        runOp("aa_55", 8'hAA, 8'h55, 1'b0);
        runOp("ff_ff", 8'hFF, 8'hFF, 1'b0);
        runOp("borrow_in", 8'h7F, 8'h7F, 1'b1);

        // A start pulse during RUN is ignored. A start during the done pulse
        // is accepted back-to-back.
        applyStimulus(8'h3C, 8'h1E, 1'b0);
        waitDone("ignore_run_start", 8'h3C, 8'h1E, 1'b0, 3);
        applyStimulus(8'h10, 8'h20, 1'b1);
        waitDone("back_to_back", 8'h10, 8'h20, 1'b1, 0);
        @(posedge iClk);
        #1;
        checkOutput("back_to_back_done_end", 32'(bus.oDone), 32'd0);

        // Reset asserted mid-RUN: outputs clear immediately and no done follows.
        applyStimulus(8'hC3, 8'h5A, 1'b1);
        repeat (4) @(posedge iClk);
        #2;
        iRst = 1'b1;
        #1;
        checkOutput("abort_data", 32'(bus.oData), 32'd0);
        checkOutput("abort_borrow", 32'(bus.oData_B), 32'd0);
        checkOutput("abort_busy", 32'(bus.oBusy), 32'd0);
        checkOutput("abort_done", 32'(bus.oDone), 32'd0);
        @(posedge iClk);
        #1;
        iRst     = 1'b0;
        prevData = '0;
        prevB    = 1'b0;
        sawDone  = 0;
        repeat (WIDTH + 2) begin
            @(posedge iClk);
            #1;
            if (bus.oDone) sawDone = 1;
        end
        checkOutput("abort_no_done", 32'(sawDone), 32'd0);
        runOp("after_abort", 8'h12, 8'h34, 1'b0);

        // Random operations compared against the arithmetic reference.
        for (int i = 0; i < 500; i++) begin
            ra   = WIDTH'($urandom);
            rb   = WIDTH'($urandom);
            rbin = 1'($urandom);
            runOp("random", ra, rb, rbin);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
